// File: rtl/reg_bank_write_16x16.sv
// Write side of the 16 x WIDTH register bank: write demux with valid/ready handshake, plus a sequenced clear engine.
// Optional build macro REG0_ZERO_EN: R[0] is hardwired to zero and has no storage.

module reg_bank_write_16x16_slot #(
    parameter int         WIDTH = 16,
    parameter logic [3:0] IDX   = 4'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_accept,
    input  logic [3:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clr_active,
    input  logic [3:0]       clr_cnt,
    output logic [WIDTH-1:0] r_q
);

    logic [WIDTH-1:0] r_d;

    // Writes only happen in IDLE and clears only in CLEAR, so the two enables never collide.
    always_comb begin
        r_d = r_q;
        if (wr_accept && (wr_addr == IDX)) begin
            r_d = wr_data;
        end else if (clr_active && (clr_cnt == IDX)) begin
            r_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

endmodule

module reg_bank_write_16x16 #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [3:0]            wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  clr_req,
    output logic                  busy,
    output logic                  wr_done,
    output logic [16*WIDTH-1:0]   q_flat
);

    // Handshake: a write transfers on a rising edge where wr_valid and wr_ready are both 1;
    // wr_ready depends only on the state flop, so the source must hold wr_valid/wr_addr/wr_data until then.
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] clr_cnt_q, clr_cnt_d;
    logic       wr_done_q, wr_done_d;
    logic       wr_accept;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        wr_accept = 1'b0;
        case (state_q)
            IDLE: begin
                wr_accept = wr_valid;
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_cnt_d = 4'd0;
                end
            end
            CLEAR: begin
                // clr_req is not looked at here, so a repeated request cannot restart the sweep.
                clr_cnt_d = clr_cnt_q + 4'd1;
                if (clr_cnt_q == 4'd15) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        wr_done_d = wr_accept;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            clr_cnt_q <= 4'd0;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            wr_done_q <= wr_done_d;
        end
    end

    assign wr_ready = (state_q == IDLE);
    assign busy     = (state_q == CLEAR);
    assign wr_done  = wr_done_q;

    for (genvar g = 0; g < 16; g++) begin : g_reg
`ifdef REG0_ZERO_EN
        if (g == 0) begin : g_zero
            assign q_flat[WIDTH-1:0] = '0;
        end else begin : g_store
            reg_bank_write_16x16_slot #(
                .WIDTH (WIDTH),
                .IDX   (4'(g))
            ) u_slot (
                .clk        (clk),
                .rst        (rst),
                .wr_accept  (wr_accept),
                .wr_addr    (wr_addr),
                .wr_data    (wr_data),
                .clr_active (busy),
                .clr_cnt    (clr_cnt_q),
                .r_q        (q_flat[WIDTH*g +: WIDTH])
            );
        end
`else
        begin : g_store
            reg_bank_write_16x16_slot #(
                .WIDTH (WIDTH),
                .IDX   (4'(g))
            ) u_slot (
                .clk        (clk),
                .rst        (rst),
                .wr_accept  (wr_accept),
                .wr_addr    (wr_addr),
                .wr_data    (wr_data),
                .clr_active (busy),
                .clr_cnt    (clr_cnt_q),
                .r_q        (q_flat[WIDTH*g +: WIDTH])
            );
        end
`endif
    end

endmodule
